// File: rtl/sipo_8_bit_byte_receiver_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sipo_rx_pkg
// Brief   : Shared types and constants for the SIPO byte receiver.
// Revision: 1.0 - initial release
// ============================================================================
package sipo_rx_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_t;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int COUNT_WIDTH        = 4;

endpackage : sipo_rx_pkg
`default_nettype wire

// File: rtl/sipo_8_bit_byte_receiver_if.sv
`default_nettype none
// ============================================================================
// Module  : sipo_8_bit_byte_receiver_if
// Brief   : Serial input controls and parallel valid/ready output bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface sipo_8_bit_byte_receiver_if #(
    parameter int DATA_WIDTH = 8
) ();
    import sipo_rx_pkg::*;

    logic                   Enable_In;
    logic                   Frame_Start_In;
    logic                   Shift_Data_Signal_In;
    logic                   Serial_Data_In;
    logic                   Data_Ready_In;
    logic [DATA_WIDTH-1:0]  Parallel_Data_Out;
    logic                   Data_Valid_Out;
    logic                   Overrun_Error_Out;
    logic [COUNT_WIDTH-1:0] Bit_Count_Out;

    // Master is the upstream/consumer side, slave is the receiver itself
    modport master (
        output Enable_In, Frame_Start_In, Shift_Data_Signal_In, Serial_Data_In, Data_Ready_In,
        input  Parallel_Data_Out, Data_Valid_Out, Overrun_Error_Out, Bit_Count_Out
    );

    modport slave (
        input  Enable_In, Frame_Start_In, Shift_Data_Signal_In, Serial_Data_In, Data_Ready_In,
        output Parallel_Data_Out, Data_Valid_Out, Overrun_Error_Out, Bit_Count_Out
    );

endinterface : sipo_8_bit_byte_receiver_if
`default_nettype wire

// File: rtl/sipo_8_bit_byte_receiver_byte_holding_register.sv
`default_nettype none
// ============================================================================
// Module  : byte_holding_register
// Brief   : One-entry valid/ready output register with sticky overrun flag.
// Revision: 1.0 - initial release
// ============================================================================
module byte_holding_register #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load_valid,
    input  wire logic [WIDTH-1:0] i_load_data,
    input  wire logic             i_ready,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_accept;
    logic             w_drop;
    logic             w_transfer;

    // A consume on the same edge frees the slot for the incoming byte
    assign w_accept   = i_load_valid && (!r_valid || i_ready);
    assign w_drop     = i_load_valid && r_valid && !i_ready;
    assign w_transfer = r_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data  <= i_load_data;
                r_valid <= 1'b1;
            end else if (w_transfer) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule : byte_holding_register
`default_nettype wire

// File: rtl/sipo_8_bit_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module  : sipo_8_bit_byte_receiver
// Brief   : Serial-in parallel-out byte receiver with valid/ready output.
// Revision: 1.0 - initial release
// ============================================================================
module sipo_8_bit_byte_receiver
    import sipo_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter bit MSB_FIRST  = 1'b1
) (
    input wire logic                Clk_In,
    input wire logic                Reset_In,
    sipo_8_bit_byte_receiver_if.slave rx_if
);

    localparam logic [COUNT_WIDTH-1:0] c_LAST_COUNT = COUNT_WIDTH'(DATA_WIDTH - 1);

    rx_state_t              r_state;
    rx_state_t              w_state_next;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_next;
    logic [DATA_WIDTH-1:0]  r_shift;
    logic [DATA_WIDTH-1:0]  w_shift_next;
    logic [DATA_WIDTH-1:0]  w_shift_base;
    logic [DATA_WIDTH-1:0]  w_shifted;
    logic                   w_frame_start;
    logic                   w_sample;
    logic                   w_frame_done;

    assign w_frame_start = rx_if.Enable_In && rx_if.Frame_Start_In;
    assign w_sample      = rx_if.Enable_In && rx_if.Shift_Data_Signal_In;

    // A resync on the same edge as a sample shifts into an empty register
    assign w_shift_base  = w_frame_start ? '0 : r_shift;

    if (MSB_FIRST) begin : g_msb_first
        assign w_shifted = {w_shift_base[DATA_WIDTH-2:0], rx_if.Serial_Data_In};
    end else begin : g_lsb_first
        assign w_shifted = {rx_if.Serial_Data_In, w_shift_base[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_shift <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_shift_next = r_shift;
        w_frame_done = 1'b0;

        if (w_frame_start) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
            w_shift_next = '0;
        end

        if (w_sample) begin
            w_shift_next = w_shifted;
            // Resync outranks completion, so a partial byte is never emitted
            if (!w_frame_start && (r_count == c_LAST_COUNT)) begin
                w_frame_done = 1'b1;
                w_state_next = ST_IDLE;
                w_count_next = '0;
                w_shift_next = '0;
            end else begin
                w_state_next = ST_SHIFT;
                w_count_next = w_frame_start ? COUNT_WIDTH'(1) : r_count + COUNT_WIDTH'(1);
            end
        end
    end

    byte_holding_register #(
        .WIDTH (DATA_WIDTH)
    ) u_byte_holding_register (
        .clk          (Clk_In),
        .rst          (Reset_In),
        .i_load_valid (w_frame_done),
        .i_load_data  (w_shifted),
        .i_ready      (rx_if.Data_Ready_In),
        .o_data       (rx_if.Parallel_Data_Out),
        .o_valid      (rx_if.Data_Valid_Out),
        .o_overrun    (rx_if.Overrun_Error_Out)
    );

    assign rx_if.Bit_Count_Out = r_count;

endmodule : sipo_8_bit_byte_receiver
`default_nettype wire

// File: tb/tb_sipo_8_bit_byte_receiver.sv
`default_nettype none
// ============================================================================
// Module  : tb_sipo_8_bit_byte_receiver
// Brief   : Directed and random checks of the SIPO receiver against a model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sipo_8_bit_byte_receiver;
    import sipo_rx_pkg::*;

    logic Clk_In   = 1'b0;
    logic Reset_In = 1'b1;
    always #5 Clk_In = ~Clk_In;

    sipo_8_bit_byte_receiver_if #(.DATA_WIDTH(8)) rx_if ();

    sipo_8_bit_byte_receiver #(
        .DATA_WIDTH (8),
        .MSB_FIRST  (1'b1)
    ) dut (
        .Clk_In   (Clk_In),
        .Reset_In (Reset_In),
        .rx_if    (rx_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: bits of the current frame in arrival order, plus output slot
    bit         m_bits[$];
    logic [7:0] m_data  = 8'h00;
    bit         m_valid = 1'b0;
    bit         m_ovr   = 1'b0;

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit en, input bit fs, input bit sh,
                              input bit sd, input bit rdy);
        bit     done;
        int     value;
        if (rst) begin
            m_bits.delete();
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            return;
        end
        done  = 1'b0;
        value = 0;
        if (en) begin
            if (fs) m_bits.delete();
            if (sh) begin
                m_bits.push_back(sd);
                if (m_bits.size() == 8) begin
                    foreach (m_bits[i]) value = value * 2 + int'(m_bits[i]);
                    m_bits.delete();
                    done = 1'b1;
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = value[7:0];
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit fs, input bit sh,
                        input bit sd, input bit rdy);
        Reset_In                   = rst;
        rx_if.Enable_In            = en;
        rx_if.Frame_Start_In       = fs;
        rx_if.Shift_Data_Signal_In = sh;
        rx_if.Serial_Data_In       = sd;
        rx_if.Data_Ready_In        = rdy;
        @(posedge Clk_In);
        model_edge(rst, en, fs, sh, sd, rdy);
        #1;
        check8("data",    rx_if.Parallel_Data_Out,           m_data);
        check8("valid",   {7'd0, rx_if.Data_Valid_Out},      {7'd0, m_valid});
        check8("overrun", {7'd0, rx_if.Overrun_Error_Out},   {7'd0, m_ovr});
        check8("count",   {4'd0, rx_if.Bit_Count_Out},       8'(m_bits.size()));
    endtask

    task automatic send_byte(input logic [7:0] val, input bit rdy, input bit rdy_last);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, val[i], (i == 0) ? rdy_last : rdy);
        end
    endtask

    initial begin
        logic [7:0] piso;
        logic [7:0] pat;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check8("rst_data", rx_if.Parallel_Data_Out, 8'h00);

        // Reset mid-frame, then a clean byte
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check8("midrst_count", {4'd0, rx_if.Bit_Count_Out}, 8'h00);
        send_byte(8'h3C, 1'b0, 1'b0);
        check8("midrst_byte", rx_if.Parallel_Data_Out, 8'h3C);
        check8("midrst_valid", {7'd0, rx_if.Data_Valid_Out}, 8'h01);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // PISO loopback: SIPO samples the pre-shift MSB each shared shift
        piso = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, piso[7], 1'b1);
            piso = {piso[6:0], 1'b0};
            check8("loop_count", {4'd0, rx_if.Bit_Count_Out}, 8'((i + 1) % 8));
        end
        check8("loop_byte", rx_if.Parallel_Data_Out, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check8("loop_valid_drop", {7'd0, rx_if.Data_Valid_Out}, 8'h00);

        // Backpressure then overrun
        send_byte(8'h81, 1'b0, 1'b0);
        send_byte(8'h7E, 1'b0, 1'b0);
        check8("ovr_hold", rx_if.Parallel_Data_Out, 8'h81);
        check8("ovr_flag", {7'd0, rx_if.Overrun_Error_Out}, 8'h01);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check8("ovr_consumed", {7'd0, rx_if.Data_Valid_Out}, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Consume and complete on the same edge
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h22, 1'b0, 1'b1);
        check8("simul_byte", rx_if.Parallel_Data_Out, 8'h22);
        check8("simul_valid", {7'd0, rx_if.Data_Valid_Out}, 8'h01);
        check8("simul_ovr", {7'd0, rx_if.Overrun_Error_Out}, 8'h00);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Resync with a sample, enable gating mid-frame
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check8("resync_count", {4'd0, rx_if.Bit_Count_Out}, 8'h01);
        pat = 8'hF0;
        for (int i = 6; i >= 4; i--) step(1'b0, 1'b1, 1'b0, 1'b1, pat[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            check8("gate_count", {4'd0, rx_if.Bit_Count_Out}, 8'h04);
        end
        for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, 1'b0, 1'b1, pat[i], 1'b0);
        check8("resync_byte", rx_if.Parallel_Data_Out, 8'hF0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            step(($urandom % 64) == 0, ($urandom % 8) != 0, ($urandom % 24) == 0,
                 ($urandom % 4) != 0, 1'($urandom), ($urandom % 3) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sipo_8_bit_byte_receiver
`default_nettype wire

// File: doc/sipo_8_bit_byte_receiver.md
# sipo_8_bit_byte_receiver

Serial-in, parallel-out byte receiver that sits directly downstream of the 8-bit PISO shift register. It samples the PISO serial output MSB-first on qualified shift cycles and assembles 8 bits into a byte. Each completed byte is presented on a valid/ready output handshake, with a one-byte holding register and a sticky overrun flag. It closes the loopback path PISO → SIPO used for shift-register regression.

## Interface
- DATA_WIDTH, 8: bits per frame; only 8 is supported in this revision.
- MSB_FIRST, 1: 1 = first received bit lands in bit [DATA_WIDTH-1]; 0 = first received bit lands in bit [0].
- Clk_In  input  1  clock; all logic is on the rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Enable_In  input  1  receive-side enable; when low, the receive side freezes.
- Frame_Start_In  input  1  resynchronise: discard the partial byte and restart the bit count.
- Shift_Data_Signal_In  input  1  qualifies Serial_Data_In for sampling on this edge.
- Serial_Data_In  input  1  serial bit from PISO Serial_Data_Out.
- Data_Ready_In  input  1  consumer accepts Parallel_Data_Out.
- Parallel_Data_Out  output  8  assembled byte held in the output register.
- Data_Valid_Out  output  1  Parallel_Data_Out holds an unconsumed byte.
- Overrun_Error_Out  output  1  sticky flag: a completed byte was dropped.
- Bit_Count_Out  output  4  bits received in the current frame, 0..7.

## Operation
- Sample condition: a bit is sampled when Enable_In=1 and Shift_Data_Signal_In=1 at the rising edge.
- Assembly (MSB_FIRST=1): r_Shift_Register <= {r_Shift_Register[6:0], Serial_Data_In}.
- Receive FSM states:
  - ST_IDLE: count=0, no partial byte.
  - ST_SHIFT: count 1..7.
- Transitions:
  - ST_IDLE → ST_SHIFT on the first sample.
  - ST_SHIFT stays while count<7.
  - The 8th sample completes the frame: count → 0 and the FSM returns to ST_IDLE.
- Frame_Start_In=1 (requires Enable_In=1):
  - Clears count and r_Shift_Register.
  - If a sample occurs on the same edge, that bit becomes bit 1 of the new frame: count=1, state ST_SHIFT.
  - Frame_Start_In has priority over completion: a partial byte is never emitted.
- Enable_In=0: count, state and r_Shift_Register hold, and Frame_Start_In is ignored. The output handshake still operates.
- Output holding register, on frame completion:
  - Empty, or Data_Ready_In=1 on the same edge: load the byte; Data_Valid_Out=1.
  - Full and Data_Ready_In=0: new byte dropped, old byte retained, Overrun_Error_Out set to 1.
- Handshake: a transfer occurs on an edge where Data_Valid_Out=1 and Data_Ready_In=1. Data_Valid_Out clears unless a new byte loads on the same edge.
- Parallel_Data_Out is stable while Data_Valid_Out=1 and not yet transferred.
- Overrun_Error_Out is cleared only by Reset_In.
- X/Z on Serial_Data_In is captured as-is; the block does not filter it.

## Timing
- Reset_In=1 at an edge forces the following, mid-frame or not:
  - Parallel_Data_Out=0x00
  - Data_Valid_Out=0
  - Overrun_Error_Out=0
  - Bit_Count_Out=0
  - state ST_IDLE
  - Reset overrides all other inputs on that edge.
- Latency: Data_Valid_Out rises on the same edge that samples the 8th bit, i.e. visible 1 cycle after that sample is presented.
- Throughput: one byte per 8 qualified edges; back-to-back frames need no gap cycle.
- PISO pairing: drive the PISO shift and SIPO sample from the same Shift_Data_Signal_In. The SIPO samples the pre-shift PISO bit, so 8 shifts after a PISO load deliver bits 7..0.
- Bit_Count_Out is registered and reflects the count after the current edge.

## Structure
- Package sipo_rx_pkg:
  - typedef enum logic {ST_IDLE, ST_SHIFT} rx_state_t
  - localparam DATA_WIDTH_DEFAULT=8
  - localparam COUNT_WIDTH=4
- One sub-module, byte_holding_register: a one-entry valid/ready register with overrun detect, instantiated once.

## Test plan
- Reset mid-frame:
  - Stimulus: sample 3 bits, then assert Reset_In for 1 cycle, then send 0x3C.
  - Response: all outputs 0 after reset; then Parallel_Data_Out=0x3C with Data_Valid_Out=1.
- Loopback:
  - Stimulus: PISO loads 0xA5, then 8 shared shifts with Data_Ready_In=1.
  - Response: bits 1,0,1,0,0,1,0,1 received; Parallel_Data_Out=0xA5; Data_Valid_Out high 1 cycle; Bit_Count_Out 1..7,0.
- Backpressure/overrun:
  - Stimulus: send 0x81 then 0x7E with Data_Ready_In=0.
  - Response: Parallel_Data_Out stays 0x81; Overrun_Error_Out=1 after the 8th bit of 0x7E. Then Data_Ready_In=1 for 1 cycle → Data_Valid_Out=0.
- Simultaneous consume and complete:
  - Stimulus: hold 0x11 valid; assert Data_Ready_In on the edge that completes 0x22.
  - Response: Parallel_Data_Out=0x22; Data_Valid_Out stays 1; no overrun.
- Resync and enable gating:
  - Stimulus: 4 bits, then Frame_Start_In plus a sample of 1, then 7 more bits of 0xF0 pattern; Enable_In=0 for 3 cycles mid-frame with Shift_Data_Signal_In=1.
  - Response: partial byte discarded; Bit_Count_Out frozen while Enable_In=0; received byte = 0xF0.
